// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 codes, FSM states,
// iteration count and a conditional two's-complement helper.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ITER_CNT   = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negate when n is set; used for magnitudes and sign fix-up.
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared datapath for the iterative multiply/divide: a 64-bit shift register and one
// 33-bit adder that either adds (shift-add multiply) or subtracts (restoring divide).
//  Multiply: acc = {hi, multiplier}; operand = multiplicand; after 32 steps acc = product.
//  Divide:   acc = {rem, dividend};  operand = divisor;      after 32 steps acc = {rem, quot}.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic                i_en,
    input  logic                i_is_div,
    input  logic [2*XLEN-1:0]   i_init,
    input  logic [XLEN-1:0]     i_opnd,
    output logic [2*XLEN-1:0]   o_acc
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;

    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN+1:0]   w_sum;
    logic [2*XLEN-1:0] w_step;

    // Operand selection for the shared adder; divide subtracts via invert plus carry-in.
    always_comb begin
        w_add_a = i_is_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
        w_add_b = i_is_div ? ~{1'b0, r_opnd}        : {1'b0, r_opnd};
        w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, i_is_div};
    end

    // One algorithm step: carry out of the subtract means the shifted remainder >= divisor.
    always_comb begin
        if (i_is_div) begin
            w_step = w_sum[XLEN+1] ? {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                                   : {r_acc[2*XLEN-2:0], 1'b0};
        end else begin
            w_step = r_acc[0] ? {w_sum[XLEN:0], r_acc[XLEN-1:1]}
                              : {1'b0, r_acc[2*XLEN-1:1]};
        end
    end

    // Load operands on accept, then advance one step per enabled cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_acc  <= i_init;
            r_opnd <= i_opnd;
        end else if (i_en) begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            r_acc  <= w_step;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One operation in flight; special divide cases
// (divide-by-zero, signed overflow) bypass the datapath and complete on the next edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int P_XLEN       = XLEN,
    parameter int P_REG_ADDR_W = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              funct3,
    input  logic [P_XLEN-1:0]       rs1_data,
    input  logic [P_XLEN-1:0]       rs2_data,
    input  logic [P_REG_ADDR_W-1:0] rd_in,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P_XLEN-1:0]       result,
    output logic [P_REG_ADDR_W-1:0] rd_out
);

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [XLEN-1:0]         r_result;
    logic [P_REG_ADDR_W-1:0] r_rd_out;
    logic [2:0]              r_funct3;
    logic [4:0]              r_cnt;
    logic                    r_neg_q;
    logic                    r_neg_r;

    logic                    w_accept;
    logic                    w_sign_a;
    logic                    w_sign_b;
    logic [XLEN-1:0]         w_mag_a;
    logic [XLEN-1:0]         w_mag_b;
    logic                    w_div_zero;
    logic                    w_overflow;
    logic                    w_fast;
    logic [XLEN-1:0]         w_fast_result;
    logic [2*XLEN-1:0]       w_acc;
    logic [2*XLEN-1:0]       w_prod;
    logic [XLEN-1:0]         w_fix_result;

    assign w_accept = in_valid && r_in_ready && !flush;

    // Operand signedness, magnitudes and fast-path detection on the request inputs.
    always_comb begin
        w_sign_a = rs1_data[XLEN-1] && (funct3 == F3_MUL || funct3 == F3_MULH ||
                   funct3 == F3_MULHSU || funct3 == F3_DIV || funct3 == F3_REM);
        w_sign_b = rs2_data[XLEN-1] && (funct3 == F3_MUL || funct3 == F3_MULH ||
                   funct3 == F3_DIV || funct3 == F3_REM);
        w_mag_a  = neg_if(w_sign_a, rs1_data);
        w_mag_b  = neg_if(w_sign_b, rs2_data);

        w_div_zero = funct3[2] && (rs2_data == '0);
        w_overflow = (funct3 == F3_DIV || funct3 == F3_REM) &&
                     (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
        w_fast     = w_div_zero || w_overflow;

        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        if (w_div_zero) w_fast_result = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        else            w_fast_result = funct3[1] ? 32'h0    : 32'h8000_0000;
    end

    muldiv_iter u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept && !w_fast),
        .i_en     (r_state == S_RUN),
        .i_is_div (r_funct3[2]),
        .i_init   ({{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)}),
        .i_opnd   (funct3[2] ? w_mag_b : w_mag_a),
        .o_acc    (w_acc)
    );

    // Sign fix-up of the finished magnitude result and selection of the returned half.
    always_comb begin
        w_prod = r_neg_q ? (~w_acc + 64'd1) : w_acc;
        case (r_funct3)
            F3_MUL:                       w_fix_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              w_fix_result = neg_if(r_neg_q, w_acc[XLEN-1:0]);
            default:                      w_fix_result = neg_if(r_neg_r, w_acc[2*XLEN-1:XLEN]);
        endcase
    end

    // Control FSM: accept, iterate, fix-up, hold result until consumed; flush wins over all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rd_out    <= '0;
            r_funct3    <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_funct3   <= funct3;
                        r_rd_out   <= rd_in;
                        r_neg_q    <= w_sign_a ^ w_sign_b;
                        r_neg_r    <= w_sign_a;
                        if (w_fast) begin
                            r_result    <= w_fast_result;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt   <= 5'(ITER_CNT - 1);
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == 5'd0) r_state <= S_DONE;
                    else               r_cnt   <= r_cnt - 5'd1;
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_result    <= w_fix_result;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign rd_out    = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, handshake, flush and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at the next edge and measure edges until out_valid (-1 on timeout).
    // Leaves the result un-consumed; the caller decides when to pulse out_ready.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        @(negedge clk);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; rd_in = 5'd0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=00000000", result); end
        n_cmp++; if (rd_out !== 5'd0) begin n_err++; $display("FAIL reset_rd_out got=%0d exp=0", rd_out); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_mul();
        logic [2:0]  f3 [4]  = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU};
        logic [31:0] a  [4]  = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b  [4]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex [4]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [4:0]  rd [4]  = '{5'd17, 5'd3, 5'd31, 5'd8};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(f3[i], a[i], b[i], rd[i], lat);
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul%0d_latency got=%0d exp=33", i, lat); end
            n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL mul%0d_result got=%h exp=%h", i, result, ex[i]); end
            n_cmp++; if (rd_out !== rd[i]) begin n_err++; $display("FAIL mul%0d_rd got=%0d exp=%0d", i, rd_out, rd[i]); end
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3 [5]  = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV};
        logic [31:0] a  [5]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd100};
        logic [31:0] b  [5]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] ex [5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFF2};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(f3[i], a[i], b[i], 5'(i + 1), lat);
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div%0d_latency got=%0d exp=33", i, lat); end
            n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL div%0d_result got=%h exp=%h", i, result, ex[i]); end
            consume();
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  f3 [5]  = '{F3_DIV, F3_REM, F3_DIV, F3_REM, F3_DIVU};
        logic [31:0] a  [5]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [5]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ex [5]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(f3[i], a[i], b[i], 5'd12, lat);
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL fast%0d_latency got=%0d exp=1", i, lat); end
            n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL fast%0d_result got=%h exp=%h", i, result, ex[i]); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(F3_DIVU, 32'd100, 32'd7, 5'd9, lat);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL bp_latency got=%0d exp=33", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || result !== 32'd14 || rd_out !== 5'd9 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got v=%b r=%h rd=%0d rdy=%b exp v=1 r=0000000e rd=9 rdy=0",
                         c, out_valid, result, rd_out, in_ready);
            end
        end
        consume();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        bit seen;
        // Accept, run 10 RUN cycles, then flush.
        @(negedge clk);
        funct3 = F3_MUL; rs1_data = 32'd3; rs2_data = 32'd4; rd_in = 5'd5; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_run got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_result got=%b exp=0", seen); end
        // Flush together with a request in IDLE must not accept it.
        @(negedge clk);
        funct3 = F3_DIV; rs1_data = 32'd5; rs2_data = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_idle got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        funct3 = F3_DIVU; rs1_data = 32'd50; rs2_data = 32'd3; rd_in = 5'd22; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2; reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got v=%b r=%h rd=%0d rdy=%b exp all 0", out_valid, result, rd_out, in_ready);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        // Unit recovers; rd_in==0 still produces a normal result.
        issue(F3_MUL, 32'd6, 32'd7, 5'd0, lat);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL post_reset_latency got=%0d exp=33", lat); end
        n_cmp++; if (result !== 32'd42) begin n_err++; $display("FAIL post_reset_result got=%h exp=0000002a", result); end
        n_cmp++; if (rd_out !== 5'd0) begin n_err++; $display("FAIL post_reset_rd got=%0d exp=0", rd_out); end
        consume();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; funct3 = 3'b0; rs1_data = '0; rs2_data = '0;
        rd_in = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
